// File: rtl/alu_int_arbiter.sv
// Two-requester round-robin front end for a shared integer ALU.
// One operation in flight: grant in IDLE, capture in ISSUE, hold result in RESP.
module alu_int_arbiter #(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [WORDSIZE-1:0] req0_a,
    input  logic [WORDSIZE-1:0] req0_b,
    input  logic [9:0]          req0_op,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [WORDSIZE-1:0] req1_a,
    input  logic [WORDSIZE-1:0] req1_b,
    input  logic [9:0]          req1_op,
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [WORDSIZE-1:0] rsp_result,
    output logic                rsp_overflow,
    output logic                rsp_illegal,
    output logic [WORDSIZE-1:0] alu_a,
    output logic [WORDSIZE-1:0] alu_b,
    output logic [9:0]          alu_op,
    input  logic [WORDSIZE-1:0] alu_out,
    input  logic                alu_overflow,
    output logic                busy
);

    localparam logic [9:0] OP_ADD = 10'h000;
    localparam logic [9:0] OP_SUB = 10'h020;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // last_q: requester served most recently; the other one wins a tie
    logic last_q, last_d;
    logic grant_q, grant_d;

    logic [WORDSIZE-1:0] a_q, a_d;
    logic [WORDSIZE-1:0] b_q, b_d;
    logic [9:0]          op_q, op_d;

    logic [WORDSIZE-1:0] result_q, result_d;
    logic                ovf_q, ovf_d;
    logic                ill_q, ill_d;

    logic any_req;
    logic sel;
    logic op_legal;
    logic rsp_hs;

    // Grant selection: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        any_req = req0_valid | req1_valid;
        sel     = 1'b0;
        if (req0_valid && req1_valid) begin
            sel = ~last_q;
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end

    // Response handshake and op decode on the latched operation
    always_comb begin
        rsp_hs   = grant_q ? (rsp1_valid & rsp1_ready)
                           : (rsp0_valid & rsp0_ready);
        op_legal = (op_q == OP_ADD) || (op_q == OP_SUB);
    end

    // State register plus all datapath/pointer flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand latch on grant, result capture in ISSUE, pointer update on response
    always_comb begin
        grant_d  = grant_q;
        last_d   = last_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = sel;
                    a_d     = sel ? req1_a  : req0_a;
                    b_d     = sel ? req1_b  : req0_b;
                    op_d    = sel ? req1_op : req0_op;
                end
            end
            ISSUE: begin
                if (op_legal) begin
                    result_d = alu_out;
                    ovf_d    = alu_overflow;
                    ill_d    = 1'b0;
                end else begin
                    result_d = '0;
                    ovf_d    = 1'b0;
                    ill_d    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    last_d = grant_q;
                end
            end
            default: begin
                last_d = last_q;
            end
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = (state_q != IDLE);
        if (state_q == IDLE && !reset) begin
            req0_ready = req0_valid & ~sel;
            req1_ready = req1_valid & sel;
        end
        if (state_q == RESP) begin
            rsp0_valid = ~grant_q;
            rsp1_valid = grant_q;
        end
    end

    // Registered values driven to the ALU and the response channels
    always_comb begin
        alu_a        = a_q;
        alu_b        = b_q;
        alu_op       = op_q;
        rsp_result   = result_q;
        rsp_overflow = ovf_q;
        rsp_illegal  = ill_q;
    end

endmodule

// File: tb/tb_alu_int_arbiter.sv
// Directed bench for alu_int_arbiter with a behavioural add/sub ALU.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_alu_int_arbiter;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic [9:0]   req0_op;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic [9:0]   req1_op;
    logic         rsp0_valid, rsp0_ready;
    logic         rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_overflow, rsp_illegal;
    logic [W-1:0] alu_a, alu_b;
    logic [9:0]   alu_op;
    logic [W-1:0] alu_out;
    logic         alu_overflow;
    logic         busy;

    int errors;
    int checks;

    alu_int_arbiter #(.WORDSIZE(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_op      (req0_op),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_op      (req1_op),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_illegal  (rsp_illegal),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_out      (alu_out),
        .alu_overflow (alu_overflow),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: sub for 020, add otherwise, signed overflow flag
    always_comb begin
        if (alu_op == 10'h020) begin
            alu_out      = alu_a - alu_b;
            alu_overflow = (alu_a[W-1] != alu_b[W-1]) &&
                           (alu_out[W-1] != alu_a[W-1]);
        end else begin
            alu_out      = alu_a + alu_b;
            alu_overflow = (alu_a[W-1] == alu_b[W-1]) &&
                           (alu_out[W-1] != alu_a[W-1]);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step;
        step;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready_in_reset: got %b%b want 00", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
        step;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags: got busy=%b v0=%b v1=%b want 000", busy, rsp0_valid, rsp1_valid);
        end
        checks++;
        if (rsp_result !== '0 || rsp_overflow !== 1'b0 || rsp_illegal !== 1'b0) begin
            errors++;
            $display("FAIL rst_rsp: got %h %b %b want 0 0 0", rsp_result, rsp_overflow, rsp_illegal);
        end
        checks++;
        if (alu_a !== '0 || alu_b !== '0 || alu_op !== 10'h000) begin
            errors++;
            $display("FAIL rst_alu: got %h %h %h want 0", alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_single_add;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req0_a = 64'd5;
        req0_b = 64'd7;
        req0_op = 10'h000;
        req0_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_grant: got %b%b want 10", req0_ready, req1_ready);
        end
        step;
        req0_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || rsp0_valid !== 1'b0 || alu_a !== 64'd5 || alu_b !== 64'd7) begin
            errors++;
            $display("FAIL add_issue: got busy=%b v0=%b a=%0d b=%0d want 1 0 5 7", busy, rsp0_valid, alu_a, alu_b);
        end
        step;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_rsp_valid: got %b%b want 10", rsp0_valid, rsp1_valid);
        end
        checks++;
        if (rsp_result !== 64'd12 || rsp_illegal !== 1'b0) begin
            errors++;
            $display("FAIL add_result: got %0d ill=%b want 12 ill=0", rsp_result, rsp_illegal);
        end
        step;
        checks++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL add_done: got v0=%b busy=%b want 0 0", rsp0_valid, busy);
        end
    endtask

    task automatic test_tie;
        int g;
        int ph;
        reset = 1'b1;
        req0_a = 64'd1;
        req0_b = 64'd2;
        req0_op = 10'h000;
        req1_a = 64'd10;
        req1_b = 64'd20;
        req1_op = 10'h000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        step;
        reset = 1'b0;
        for (int s = 0; s < 12; s++) begin
            #1;
            g = (s / 3) % 2;
            ph = s % 3;
            checks++;
            if (req0_ready !== (ph == 0 && g == 0) || req1_ready !== (ph == 0 && g == 1)) begin
                errors++;
                $display("FAIL tie_grant_%0d: got %b%b want %b%b", s, req0_ready, req1_ready, (ph == 0 && g == 0), (ph == 0 && g == 1));
            end
            if (ph == 2) begin
                checks++;
                if (rsp0_valid !== (g == 0) || rsp1_valid !== (g == 1) || rsp_result !== (g == 1 ? 64'd30 : 64'd3)) begin
                    errors++;
                    $display("FAIL tie_rsp_%0d: got v=%b%b r=%0d want v=%b%b r=%0d", s, rsp0_valid, rsp1_valid, rsp_result, (g == 0), (g == 1), (g == 1 ? 30 : 3));
                end
            end
            step;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step;
    endtask

    task automatic test_backpressure;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        req0_a = 64'd100;
        req0_b = 64'd23;
        req0_op = 10'h000;
        req0_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_grant0: got %b want 1", req0_ready);
        end
        step;
        req0_valid = 1'b0;
        req1_a = 64'd0;
        req1_b = 64'd1;
        req1_op = 10'h020;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_issue_ready1: got %b want 0", req1_ready);
        end
        step;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rsp0_valid !== 1'b1 || rsp_result !== 64'd123 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v0=%b r=%0d rdy1=%b want 1 123 0", i, rsp0_valid, rsp_result, req1_ready);
            end
            step;
        end
        rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b0 || rsp0_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got rdy1=%b v0=%b want 0 1", req1_ready, rsp0_valid);
        end
        step;
        checks++;
        if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_grant1: got rdy1=%b v0=%b want 1 0", req1_ready, rsp0_valid);
        end
        step;
        req1_valid = 1'b0;
        step;
        checks++;
        if (rsp1_valid !== 1'b1 || rsp_result !== {W{1'b1}} || rsp_overflow !== 1'b0 || rsp_illegal !== 1'b0) begin
            errors++;
            $display("FAIL bp_sub_wrap: got v1=%b r=%h o=%b i=%b want 1 ffffffffffffffff 0 0", rsp1_valid, rsp_result, rsp_overflow, rsp_illegal);
        end
        step;
    endtask

    task automatic test_sub_overflow;
        rsp1_ready = 1'b1;
        req1_a = 64'h8000_0000_0000_0000;
        req1_b = 64'd1;
        req1_op = 10'h020;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL ovf_grant: got %b want 1", req1_ready);
        end
        step;
        req1_valid = 1'b0;
        step;
        checks++;
        if (rsp1_valid !== 1'b1 || rsp_result !== 64'h7fff_ffff_ffff_ffff || rsp_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_result: got v1=%b r=%h o=%b want 1 7fffffffffffffff 1", rsp1_valid, rsp_result, rsp_overflow);
        end
        step;
    endtask

    task automatic test_illegal;
        rsp0_ready = 1'b1;
        req0_a = 64'd9;
        req0_b = 64'd9;
        req0_op = 10'h3ff;
        req0_valid = 1'b1;
        step;
        req0_valid = 1'b0;
        #1;
        checks++;
        if (alu_op !== 10'h3ff) begin
            errors++;
            $display("FAIL ill_alu_op: got %h want 3ff", alu_op);
        end
        step;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp_illegal !== 1'b1 || rsp_result !== '0 || rsp_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ill_rsp: got v0=%b i=%b r=%h o=%b want 1 1 0 0", rsp0_valid, rsp_illegal, rsp_result, rsp_overflow);
        end
        step;
    endtask

    task automatic test_withdraw;
        rsp0_ready = 1'b0;
        req0_a = 64'd2;
        req0_b = 64'd3;
        req0_op = 10'h000;
        req0_valid = 1'b1;
        step;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        step;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        step;
        #1;
        checks++;
        if (req1_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_idle: got rdy1=%b busy=%b want 0 0", req1_ready, busy);
        end
        step;
        checks++;
        if (busy !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL wd_no_grant: got busy=%b v1=%b want 0 0", busy, rsp1_valid);
        end
    endtask

    task automatic test_reset_in_resp;
        rsp0_ready = 1'b0;
        req0_a = 64'd4;
        req0_b = 64'd4;
        req0_op = 10'h000;
        req0_valid = 1'b1;
        step;
        req0_valid = 1'b0;
        step;
        checks++;
        if (rsp0_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_pre: got v0=%b want 1", rsp0_valid);
        end
        reset = 1'b1;
        step;
        reset = 1'b0;
        #1;
        checks++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0 || rsp_result !== '0) begin
            errors++;
            $display("FAIL rr_abort: got v0=%b busy=%b r=%h want 0 0 0", rsp0_valid, busy, rsp_result);
        end
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                errors++;
                $display("FAIL rr_no_pulse_%0d: got %b%b want 00", i, rsp0_valid, rsp1_valid);
            end
        end
        rsp0_ready = 1'b1;
        req0_a = 64'd6;
        req0_b = 64'd1;
        req1_a = 64'd50;
        req1_b = 64'd50;
        req1_op = 10'h000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rr_tie: got %b%b want 10", req0_ready, req1_ready);
        end
        step;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp_result !== 64'd7) begin
            errors++;
            $display("FAIL rr_after: got v0=%b r=%0d want 1 7", rsp0_valid, rsp_result);
        end
        step;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0;
        req0_b = '0;
        req0_op = '0;
        req1_a = '0;
        req1_b = '0;
        req1_op = '0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        test_reset;
        test_single_add;
        test_tie;
        test_backpressure;
        test_sub_overflow;
        test_illegal;
        test_withdraw;
        test_reset_in_resp;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
